// File: rtl/fm_spy_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fm_spy_ctrl_if
// Description : Bundle of the command, spy-port and dump-stream signals
//               between the spy-buffer command sequencer and its
//               surroundings (host front-end, spy-buffer array, dump sink).
// Revision    : 1.0 - initial release
// ============================================================================
interface fm_spy_ctrl_if #(
  parameter int SB_N   = 29,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  localparam int SB_W = $clog2(SB_N);

  // Host command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SB_W-1:0]   cmd_sb;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  // Spy-buffer array controls
  logic [SB_N-1:0]   freeze;
  logic [SB_N-1:0]   sb_reset;
  logic [SB_N-1:0]   sb_enable;
  logic [SB_N-1:0]   sb_wr_enable;
  logic [ADDR_W-1:0] sb_addr;
  logic [DATA_W-1:0] sb_wr_data;
  logic [DATA_W-1:0] sb_rd_data;

  // Dump stream
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  // Status
  logic              busy;
  logic              err;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_op, cmd_sb, cmd_addr, cmd_len,
    input  sb_rd_data, dump_ready,
    output cmd_ready,
    output freeze, sb_reset, sb_enable, sb_wr_enable, sb_addr, sb_wr_data,
    output dump_valid, dump_data, dump_last,
    output busy, err
  );

  // Host / spy-array / sink side
  modport slave (
    output cmd_valid, cmd_op, cmd_sb, cmd_addr, cmd_len,
    output sb_rd_data, dump_ready,
    input  cmd_ready,
    input  freeze, sb_reset, sb_enable, sb_wr_enable, sb_addr, sb_wr_data,
    input  dump_valid, dump_data, dump_last,
    input  busy, err
  );
endinterface
`default_nettype wire

// File: rtl/fm_spy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fm_spy_ctrl
// Description : Command sequencer for the fast-monitor spy buffers. Accepts
//               one FREEZE / RELEASE / INIT / DUMP command at a time for a
//               single buffer, drives that buffer's freeze, reset and spy
//               port, and streams dumped words over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_spy_ctrl #(
  parameter int                 SB_N         = 29,
  parameter int                 ADDR_W       = 10,
  parameter int                 DATA_W       = 32,
  parameter logic [DATA_W-1:0]  INIT_PATTERN = 32'h0fa5fa50,
  parameter int                 RST_PULSE    = 4
) (
  input  wire logic         spy_clock,
  input  wire logic         axi_reset_n,
  fm_spy_ctrl_if.master     bus
);

  localparam int SB_W = $clog2(SB_N);
  localparam int RC_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  // Command opcodes
  localparam logic [1:0] OP_FREEZE  = 2'd0;
  localparam logic [1:0] OP_RELEASE = 2'd1;
  localparam logic [1:0] OP_INIT    = 2'd2;
  localparam logic [1:0] OP_DUMP    = 2'd3;

  // Sequencer states
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST       = 3'd1;
  localparam logic [2:0] S_INIT      = 3'd2;
  localparam logic [2:0] S_DUMP_RD   = 3'd3;
  localparam logic [2:0] S_DUMP_WAIT = 3'd4;
  localparam logic [2:0] S_DUMP_OUT  = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   FULL_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [SB_N-1:0]   ONE_HOT0  = {{(SB_N-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [SB_N-1:0]   freeze_reg;
  logic [SB_W-1:0]   sel_sb;      // buffer latched at command acceptance
  logic [ADDR_W-1:0] addr_cnt;    // drives sb_addr directly, so it holds when idle
  logic [ADDR_W:0]   words_left;  // one extra bit so a full-depth dump fits
  logic [RC_W-1:0]   rst_cnt;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] dump_word;
  logic              err_pulse;

  logic              accept;
  logic              sb_in_range;
  logic              reject;
  logic [SB_N-1:0]   sel_onehot;
  logic              in_rst;
  logic              in_init;

  assign accept      = bus.cmd_valid && (state == S_IDLE);
  assign sb_in_range = (32'(bus.cmd_sb) < SB_N);
  // A dump from a buffer that is still capturing would read moving data.
  assign reject      = !sb_in_range ||
                       ((bus.cmd_op == OP_DUMP) && !freeze_reg[bus.cmd_sb]);

  assign sel_onehot  = ONE_HOT0 << sel_sb;
  assign in_rst      = (state == S_RST);
  assign in_init     = (state == S_INIT);

  // Freeze register: only FREEZE / RELEASE touch it; INIT overrides the output only.
  always_ff @(posedge spy_clock or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      freeze_reg <= '0;
    end else if (accept && !reject) begin
      if (bus.cmd_op == OP_FREEZE) begin
        freeze_reg[bus.cmd_sb] <= 1'b1;
      end else if (bus.cmd_op == OP_RELEASE) begin
        freeze_reg[bus.cmd_sb] <= 1'b0;
      end
    end
  end

  // Rejected commands raise a single-cycle error strobe.
  always_ff @(posedge spy_clock or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= accept && reject;
    end
  end

  // Main sequencer: state, address/word counters and data registers.
  always_ff @(posedge spy_clock or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state      <= S_IDLE;
      sel_sb     <= '0;
      addr_cnt   <= '0;
      words_left <= '0;
      rst_cnt    <= '0;
      wr_data    <= '0;
      dump_word  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && !reject) begin
            if (bus.cmd_op == OP_INIT) begin
              sel_sb   <= bus.cmd_sb;
              addr_cnt <= '0;
              wr_data  <= INIT_PATTERN;
              rst_cnt  <= RC_W'(RST_PULSE - 1);
              state    <= S_RST;
            end else if (bus.cmd_op == OP_DUMP) begin
              sel_sb     <= bus.cmd_sb;
              addr_cnt   <= bus.cmd_addr;
              words_left <= (bus.cmd_len == '0) ? FULL_LEN : {1'b0, bus.cmd_len};
              state      <= S_DUMP_RD;
            end
          end
        end

        S_RST: begin
          if (rst_cnt == '0) begin
            state <= S_INIT;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end

        // Address stays on the last location when done, so sb_addr holds it.
        S_INIT: begin
          if (addr_cnt == ADDR_LAST) begin
            state <= S_IDLE;
          end else begin
            addr_cnt <= addr_cnt + 1'b1;
          end
        end

        S_DUMP_RD: begin
          state <= S_DUMP_WAIT;
        end

        // Read data arrives one cycle after the enable.
        S_DUMP_WAIT: begin
          dump_word <= bus.sb_rd_data;
          state     <= S_DUMP_OUT;
        end

        S_DUMP_OUT: begin
          if (bus.dump_ready) begin
            if (words_left == ADDR_W'(1)) begin
              state <= S_IDLE;
            end else begin
              addr_cnt   <= addr_cnt + 1'b1;  // wraps modulo memory depth
              words_left <= words_left - 1'b1;
              state      <= S_DUMP_RD;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign bus.cmd_ready    = (state == S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.err          = err_pulse;
  assign bus.freeze       = freeze_reg | ((in_rst || in_init) ? sel_onehot : '0);
  assign bus.sb_reset     = in_rst ? sel_onehot : '0;
  assign bus.sb_enable    = (in_init || (state == S_DUMP_RD)) ? sel_onehot : '0;
  assign bus.sb_wr_enable = in_init ? sel_onehot : '0;
  assign bus.sb_addr      = addr_cnt;
  assign bus.sb_wr_data   = wr_data;
  assign bus.dump_valid   = (state == S_DUMP_OUT);
  assign bus.dump_data    = dump_word;
  assign bus.dump_last    = (state == S_DUMP_OUT) && (words_left == ADDR_W'(1));

endmodule
`default_nettype wire

// File: tb/tb_fm_spy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_spy_ctrl
// Description : Directed self-checking bench for fm_spy_ctrl with a 16-word
//               spy memory model that returns its own address as data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_spy_ctrl;

  localparam int SB_N   = 29;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam logic [31:0] PAT = 32'h0fa5fa50;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  fm_spy_ctrl_if #(.SB_N(SB_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fm_spy_ctrl #(
    .SB_N(SB_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .INIT_PATTERN(PAT), .RST_PULSE(4)
  ) dut (
    .spy_clock   (clk),
    .axi_reset_n (rst_n),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Spy memory model: registered read of the enabled buffer, data = address.
  always @(posedge clk) begin
    if (|bus.sb_enable && !(|bus.sb_wr_enable))
      bus.sb_rd_data <= {28'd0, bus.sb_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one command for one cycle; returns at the view of cycle T+1.
  task automatic send(input logic [1:0] op, input logic [4:0] sb,
                      input logic [3:0] a, input logic [3:0] l);
    chk("cmd_ready_pre", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_sb    = sb;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Consume n dump words starting at address 'first' from buffer sb;
  // word index 'stall' is held with dump_ready low for 5 cycles.
  task automatic dump_expect(input int n, input int first, input int sb, input int stall);
    int cnt;
    for (int k = 0; k < n; k++) begin
      chk("dump_rd_en", 32'(bus.sb_enable), 32'(1) << sb);
      chk("dump_rd_addr", 32'(bus.sb_addr), 32'((first + k) % 16));
      cnt = 0;
      while (!bus.dump_valid && cnt < 10) begin
        tick();
        cnt++;
      end
      chk("dump_latency", 32'(cnt), 32'd2);
      chk("dump_data", bus.dump_data, 32'((first + k) % 16));
      chk("dump_last", 32'(bus.dump_last), 32'(k == n - 1));
      if (k == stall) begin
        bus.dump_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("stall_valid", 32'(bus.dump_valid), 32'd1);
          chk("stall_data", bus.dump_data, 32'((first + k) % 16));
          chk("stall_last", 32'(bus.dump_last), 32'(k == n - 1));
        end
      end
      bus.dump_ready = 1'b1;
      tick();
      bus.dump_ready = 1'b0;
    end
    chk("dump_done_ready", 32'(bus.cmd_ready), 32'd1);
    chk("dump_done_valid", 32'(bus.dump_valid), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_sb     = 5'd0;
    bus.cmd_addr   = 4'd0;
    bus.cmd_len    = 4'd0;
    bus.dump_ready = 1'b0;
    bus.sb_rd_data = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_freeze", 32'(bus.freeze), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_enable", 32'(bus.sb_enable), 32'd0);
    chk("rst_sb_reset", 32'(bus.sb_reset), 32'd0);
    chk("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst_sb_addr", 32'(bus.sb_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // FREEZE / RELEASE sb=5
    send(2'd0, 5'd5, 4'd0, 4'd0);
    chk("freeze5", 32'(bus.freeze), 32'h20);
    chk("freeze5_ready", 32'(bus.cmd_ready), 32'd1);
    chk("freeze5_err", 32'(bus.err), 32'd0);
    send(2'd1, 5'd5, 4'd0, 4'd0);
    chk("release5", 32'(bus.freeze), 32'h0);
    chk("release5_ready", 32'(bus.cmd_ready), 32'd1);
    chk("release5_err", 32'(bus.err), 32'd0);

    // INIT sb=3
    send(2'd2, 5'd3, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      chk("init_sb_reset", 32'(bus.sb_reset), 32'h8);
      chk("init_rst_freeze", 32'(bus.freeze), 32'h8);
      chk("init_rst_enable", 32'(bus.sb_enable), 32'd0);
      chk("init_rst_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      chk("init_wr_enable", 32'(bus.sb_wr_enable), 32'h8);
      chk("init_enable", 32'(bus.sb_enable), 32'h8);
      chk("init_addr", 32'(bus.sb_addr), 32'(i));
      chk("init_data", bus.sb_wr_data, PAT);
      chk("init_freeze", 32'(bus.freeze), 32'h8);
      chk("init_sb_reset_low", 32'(bus.sb_reset), 32'd0);
      tick();
    end
    chk("init_done_ready", 32'(bus.cmd_ready), 32'd1);
    chk("init_done_freeze", 32'(bus.freeze), 32'd0);
    chk("init_done_enable", 32'(bus.sb_enable), 32'd0);

    // FREEZE sb=7, DUMP addr=14 len=4 with wraparound and a stall on word 2
    send(2'd0, 5'd7, 4'd0, 4'd0);
    chk("freeze7", 32'(bus.freeze), 32'h80);
    send(2'd3, 5'd7, 4'd14, 4'd4);
    dump_expect(4, 14, 7, 1);
    chk("dump7_freeze_kept", 32'(bus.freeze), 32'h80);

    // Rejected commands: DUMP to unfrozen sb=2, FREEZE with sb=29
    send(2'd3, 5'd2, 4'd3, 4'd2);
    chk("rej_dump_err", 32'(bus.err), 32'd1);
    chk("rej_dump_freeze", 32'(bus.freeze), 32'h80);
    chk("rej_dump_enable", 32'(bus.sb_enable), 32'd0);
    chk("rej_dump_busy", 32'(bus.busy), 32'd0);
    chk("rej_dump_addr", 32'(bus.sb_addr), 32'd1);
    tick();
    chk("rej_dump_err_end", 32'(bus.err), 32'd0);
    send(2'd0, 5'd29, 4'd0, 4'd0);
    chk("rej_sb_err", 32'(bus.err), 32'd1);
    chk("rej_sb_freeze", 32'(bus.freeze), 32'h80);
    chk("rej_sb_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("rej_sb_err_end", 32'(bus.err), 32'd0);

    // DUMP len=0 on frozen sb=0 -> 16 words
    send(2'd0, 5'd0, 4'd0, 4'd0);
    chk("freeze0", 32'(bus.freeze), 32'h81);
    send(2'd3, 5'd0, 4'd0, 4'd0);
    dump_expect(16, 0, 0, -1);

    // Reset during the 8th INIT write
    send(2'd2, 5'd1, 4'd0, 4'd0);
    repeat (4 + 7) tick();
    chk("mid_init_addr", 32'(bus.sb_addr), 32'd7);
    chk("mid_init_wr", 32'(bus.sb_wr_enable), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_enable", 32'(bus.sb_enable), 32'd0);
    chk("arst_wr_enable", 32'(bus.sb_wr_enable), 32'd0);
    chk("arst_sb_reset", 32'(bus.sb_reset), 32'd0);
    chk("arst_freeze", 32'(bus.freeze), 32'd0);
    chk("arst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("arst_sb_addr", 32'(bus.sb_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(2'd0, 5'd4, 4'd0, 4'd0);
    chk("post_rst_freeze", 32'(bus.freeze), 32'h10);
    chk("post_rst_err", 32'(bus.err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fm_spy_ctrl.md
# fm_spy_ctrl

Command sequencer for the fast-monitor spy buffers, running in the spy clock domain. It accepts one host command at a time (freeze, release, init, dump) addressed to one spy buffer. It drives that buffer's freeze, reset and spy-port signals, and streams dumped words out over a valid/ready handshake. It sits between the AXI register front-end and the spy-buffer array, replacing ad-hoc per-buffer enable, address and init logic.

## Interface
- `SB_N`, 29: number of spy buffers controlled.
- `ADDR_W`, 10: spy-port address width; memory depth is 2^ADDR_W words.
- `DATA_W`, 32: spy-port data width.
- `INIT_PATTERN`, 32'h0fa5fa50: word written by INIT.
- `RST_PULSE`, 4: sb_reset pulse length in cycles (≥1).

Ports:
- `spy_clock` in 1: sole clock.
- `axi_reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 0=FREEZE, 1=RELEASE, 2=INIT, 3=DUMP.
- `cmd_sb` in $clog2(SB_N): target buffer index.
- `cmd_addr` in ADDR_W: DUMP start address.
- `cmd_len` in ADDR_W: DUMP word count; 0 means 2^ADDR_W words.
- `freeze` out SB_N: per-buffer freeze.
- `sb_reset` out SB_N: per-buffer synchronous reset pulse.
- `sb_enable` out SB_N: one-hot spy-port enable.
- `sb_wr_enable` out SB_N: one-hot spy-port write enable.
- `sb_addr` out ADDR_W: spy-port address, shared by all buffers.
- `sb_wr_data` out DATA_W: spy-port write data.
- `sb_rd_data` in DATA_W: read data of the enabled buffer, valid 1 cycle after enable.
- `dump_valid` out 1, `dump_ready` in 1, `dump_data` out DATA_W, `dump_last` out 1: dump stream.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: one-cycle pulse on a rejected command.

## Operation
- States: IDLE, RST, INIT, DUMP_RD, DUMP_WAIT, DUMP_OUT.
- Acceptance: a command is accepted when cmd_valid & cmd_ready; all cmd_* fields are latched at acceptance.
- Rejection: a command is rejected if cmd_sb ≥ SB_N, or if it is a DUMP to an unfrozen buffer.
  - `err` pulses for 1 cycle.
  - No other output changes and the state stays IDLE.
- FREEZE / RELEASE: sets or clears the freeze register bit for cmd_sb. The state stays IDLE.
- INIT:
  - IDLE→RST: sb_reset[sb]=1 for RST_PULSE cycles.
  - RST→INIT: writes INIT_PATTERN at addresses 0..2^ADDR_W−1, one per cycle, with sb_enable[sb]=sb_wr_enable[sb]=1.
  - INIT→IDLE after the last address.
  - The freeze output for sb is forced to 1 during RST and INIT. The freeze register is unchanged; the output reverts to the register value on return to IDLE.
- DUMP:
  - The address counter loads cmd_addr and the word counter loads the effective length.
  - DUMP_RD: sb_enable[sb]=1 with sb_addr = current address. Next state DUMP_WAIT.
  - DUMP_WAIT: register sb_rd_data into dump_data, then go to DUMP_OUT.
  - DUMP_OUT: dump_valid=1 and dump_last = (remaining words == 1).
  - On dump_valid & dump_ready: if last, go to IDLE; else increment the address and go to DUMP_RD.
  - The address wraps modulo 2^ADDR_W.
- Output rules:
  - sb_enable and sb_wr_enable are zero outside DUMP_RD and INIT.
  - sb_addr and sb_wr_data hold their last value when idle.
  - At most one bit of sb_enable is set in any cycle.

## Timing
- Reset values: freeze register=0 for all buffers; all outputs 0 except cmd_ready=1; state=IDLE.
- Reset mid-operation: assertion of axi_reset_n aborts any state asynchronously, deasserting sb_reset, sb_enable and dump_valid in the same cycle.
- FREEZE/RELEASE accepted at cycle T: freeze changes at T+1; cmd_ready stays high.
- INIT accepted at T:
  - sb_reset high at T+1..T+RST_PULSE.
  - Writes occur at T+RST_PULSE+1..T+RST_PULSE+2^ADDR_W.
  - cmd_ready returns high at T+RST_PULSE+2^ADDR_W+1.
- DUMP accepted at T:
  - First read enable at T+1; dump_valid at T+3.
  - Each handshake at cycle H issues the next read at H+1 and presents the next word with dump_valid at H+3.
  - Peak rate is 1 word per 3 cycles.
- dump_valid stays high and dump_data, dump_last stay stable until handshake (no retraction).
- cmd_ready is low from T+1 until the cycle after the final INIT write or final dump handshake.
- RELEASE of a buffer is impossible while it is being dumped, because cmd_ready is low.

## Test plan
Bench settings: SB_N=29, ADDR_W=4, RST_PULSE=4.
- FREEZE sb=5, then RELEASE sb=5 → freeze=0x20 one cycle after the first accept, back to 0 after the second; cmd_ready never drops; err=0.
- INIT sb=3 accepted at T → sb_reset[3] high T+1..T+4; 16 writes of 0x0fa5fa50 to addr 0..15 at T+5..T+20 with freeze[3]=1; cmd_ready high at T+21; freeze[3]=0 afterwards.
- FREEZE sb=7, then DUMP sb=7 addr=14 len=4 (bench memory returns data = addr) → dump_data 14,15,0,1 (wraparound); dump_last only on the 4th word; dump_ready held low 5 cycles on word 2 keeps data stable.
- DUMP to unfrozen sb=2, and FREEZE with sb=29 → err pulses once each; no enable or freeze change; state stays IDLE.
- DUMP len=0 on frozen sb=0 → exactly 16 words, addr 0..15 in order.
- axi_reset_n asserted during the 8th INIT write → all outputs immediately at reset values; a subsequent command is accepted normally.
